// File: rtl/fifo_pkg.sv
// Shared FIFO package: default geometry and a constant-foldable log2 helper.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 8;

  // Ceiling log2; usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH simple dual-port storage: synchronous write, registered read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = clog2(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register holds its value unless a read is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with fill level, thresholds and sticky error flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEF_WIDTH,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned AF_LEVEL = 6,
  parameter  int unsigned AE_LEVEL = 1,
  localparam int unsigned AW       = clog2(DEPTH),
  localparam int unsigned CW       = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  // Reject illegal geometry at elaboration.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fifo_sync_param: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
    end
  endgenerate

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc_c;
  logic          rd_acc_c;

  // Status flags decode straight from the registered fill level.
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);

  assign wr_acc_c = enq & ~full;
  assign rd_acc_c = deq & ~empty;

  // Next-state for pointers, fill level, read strobe and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = rd_acc_c;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (wr_acc_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc_c) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new error outranks a clear in the same cycle.
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (enq & full)  ovf_d = 1'b1;
    if (deq & empty) unf_d = 1'b1;
  end

  // Control state registers; reset discards all queued entries at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_acc_c),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (rd_acc_c),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

  assign count      = count_q;
  assign data_valid = valid_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule
